// File: rtl/core_wb_master_pkg.sv
// core_wb_master_pkg: shared state encoding and constants for the Wishbone classic master
package core_wb_master_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;
    localparam int          TMO_W          = 8;
    localparam int          TIMEOUT_DEF    = 255;
    localparam logic [31:0] ERROR_DATA_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/core_wb_master.sv
// core_wb_master: bridges a busy/enable request port onto a single Wishbone classic bus cycle
//   clk, rst (async, active-low)
//   request side : wbAddress, wbByteSelect, wbEnable, wbWriteEnable, wbDataWrite -> wbDataRead, wbBusy, busError
//   wishbone side: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_data_o <- wb_data_i, wb_ack_i, wb_err_i
module core_wb_master
    import core_wb_master_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbEnable,
    input  logic        wbWriteEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        busError,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [27:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state, nxt;
    logic [TMO_W-1:0]  cnt;
    logic [27:0]       adr_q;
    logic [3:0]        sel_q;
    logic              we_q;
    logic [31:0]       wdat_q;
    logic [31:0]       rdat_q;
    logic              berr_q;
    logic              drop_q;
    logic              tmo;
    logic              fin;
    logic              fail;
    logic              abandon;

    // timeout fires in the last allowed bus cycle; a same-cycle ack still wins over it
    assign tmo     = cnt == TMO_LAST;
    assign fin     = wb_ack_i | wb_err_i | tmo;
    assign fail    = wb_err_i | (~wb_ack_i & tmo);
    // requester gave up at some point during the bus cycle: finish on the bus, then discard
    assign abandon = drop_q | ~wbEnable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE ? (wbEnable ? BUS : IDLE) :
              state == BUS  ? (fin ? (abandon ? DRAIN : DONE) : BUS) :
                              IDLE;
    end

    always_comb begin
        wb_cyc_o   = state == BUS;
        wb_stb_o   = state == BUS;
        wb_we_o    = state == BUS ? we_q : 1'b0;
        wb_adr_o   = state == BUS ? adr_q : '0;
        wb_sel_o   = state == BUS ? sel_q : '0;
        wb_data_o  = state == BUS ? wdat_q : '0;
        wbBusy     = state != DONE;
        wbDataRead = state == DONE ? rdat_q : ERROR_DATA;
        busError   = state == DONE ? berr_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            adr_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            wdat_q <= '0;
            rdat_q <= '0;
            berr_q <= 1'b0;
            drop_q <= 1'b0;
        end else if (state == IDLE && wbEnable) begin
            cnt    <= '0;
            adr_q  <= wbAddress;
            sel_q  <= wbByteSelect;
            we_q   <= wbWriteEnable;
            wdat_q <= wbDataWrite;
            drop_q <= 1'b0;
        end else if (state == BUS) begin
            cnt    <= cnt == '1 ? cnt : cnt + 1'b1;
            drop_q <= abandon;
            if (fin) begin
                rdat_q <= fail ? ERROR_DATA : (we_q ? 32'h0 : wb_data_i);
                berr_q <= fail;
            end
        end
    end
endmodule

// File: tb/tb_core_wb_master.sv
// tb_core_wb_master: randomized scoreboard bench for core_wb_master
module tb_core_wb_master;
    import core_wb_master_pkg::*;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [27:0] wbAddress = '0;
    logic [3:0]  wbByteSelect = '0;
    logic        wbEnable = 1'b0;
    logic        wbWriteEnable = 1'b0;
    logic [31:0] wbDataWrite = '0;
    logic [31:0] wbDataRead;
    logic        wbBusy;
    logic        busError;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [27:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    core_wb_master #(.TIMEOUT_CYCLES(TMO), .ERROR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .wbAddress(wbAddress), .wbByteSelect(wbByteSelect), .wbEnable(wbEnable),
        .wbWriteEnable(wbWriteEnable), .wbDataWrite(wbDataWrite),
        .wbDataRead(wbDataRead), .wbBusy(wbBusy), .busError(busError),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wd;
        int          len;
    } bus_t;
    typedef struct {
        logic [31:0] rd;
        logic        be;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    total = 0;
    int    bad = 0;

    // slave plan: respond in bus cycle p_d with kind 0=ack 1=err 2=err+ack 3=never
    int          p_d = 0;
    int          p_kind = 3;
    logic [31:0] p_rdata = '0;
    bit          force_ack = 0;
    bit          b2b_ok = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    int k = 0;
    always @(negedge clk) begin
        wb_data_i = $urandom;
        wb_ack_i  = force_ack;
        wb_err_i  = 1'b0;
        if (wb_cyc_o) begin
            if (k == p_d) begin
                wb_ack_i  = force_ack || p_kind == 0 || p_kind == 2;
                wb_err_i  = p_kind == 1 || p_kind == 2;
                wb_data_i = p_rdata;
            end
            k++;
        end else
            k = 0;
    end

    int mn = 0;
    always @(negedge clk) begin
        bus_t  b;
        resp_t r;
        if (!rst)
            mn = 0;
        else begin
            if (wb_cyc_o) begin
                if (bus_q.size() == 0)
                    chk("bus_unexpected", 1, 0);
                else begin
                    b = bus_q[0];
                    chk("wb_stb", wb_stb_o, 1);
                    chk("wb_adr", wb_adr_o, b.adr);
                    chk("wb_sel", wb_sel_o, b.sel);
                    chk("wb_we", wb_we_o, b.we);
                    chk("wb_data", wb_data_o, b.wd);
                end
                mn++;
            end else if (mn > 0) begin
                if (bus_q.size() > 0) begin
                    b = bus_q.pop_front();
                    chk("bus_len", mn, b.len);
                end
                mn = 0;
            end
            if (!wbBusy) begin
                if (resp_q.size() == 0)
                    chk("resp_unexpected", 1, 0);
                else begin
                    r = resp_q.pop_front();
                    chk("rdata", wbDataRead, r.rd);
                    chk("bus_error", busError, r.be);
                end
            end else begin
                chk("busy_rdata", wbDataRead, ERRD);
                chk("busy_no_err", busError, 0);
            end
        end
    end

    task automatic scramble();
        wbAddress     = 28'($urandom);
        wbByteSelect  = 4'($urandom);
        wbWriteEnable = 1'($urandom);
        wbDataWrite   = $urandom;
    endtask

    task automatic run(input logic [27:0] adr, input logic [3:0] sel, input logic we,
                       input logic [31:0] wd, input logic [31:0] rdata, input int d,
                       input int kind, input bit drop);
        bus_t  b;
        resp_t r;
        bit    tmo = kind == 3 || d >= TMO;
        bit    er = tmo || kind == 1 || kind == 2;
        bit    b2b = b2b_ok && $urandom_range(0, 1) == 1;
        bit    done = 0;
        int    lat = 0;
        if (!b2b) begin
            wbEnable = 1'b0;
            @(negedge clk);
        end
        p_d = d;
        p_kind = kind;
        p_rdata = rdata;
        wbAddress = adr;
        wbByteSelect = sel;
        wbWriteEnable = we;
        wbDataWrite = wd;
        wbEnable = 1'b1;
        b.adr = adr; b.sel = sel; b.we = we; b.wd = wd; b.len = tmo ? TMO : d + 1;
        bus_q.push_back(b);
        if (!drop) begin
            r.rd = er ? ERRD : (we ? 32'h0 : rdata);
            r.be = er;
            resp_q.push_back(r);
            for (int i = 0; i < 30 && !done; i++) begin
                @(negedge clk);
                lat++;
                if (!wbBusy)
                    done = 1;
                else if (wb_cyc_o)
                    scramble();
            end
            chk("done_seen", done, 1);
            chk("latency", lat, b.len + 1 + (b2b ? 1 : 0));
            b2b_ok = done;
        end else begin
            for (int i = 0; i < 10 && !done; i++) begin
                @(negedge clk);
                done = wb_cyc_o;
            end
            chk("drop_bus_seen", done, 1);
            wbEnable = 1'b0;
            scramble();
            done = 0;
            for (int i = 0; i < 30 && !done; i++) begin
                @(negedge clk);
                done = !wb_cyc_o;
            end
            chk("drop_bus_end", done, 1);
            chk("drain_busy", wbBusy, 1);
            b2b_ok = 0;
        end
    endtask

    initial begin
        bus_t b;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_berr", busError, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_wdata", wb_data_o, 0);
        chk("rst_busy", wbBusy, 1);
        chk("rst_rdata", wbDataRead, ERRD);
        rst = 1'b1;
        @(negedge clk);
        run(28'h000_0040, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run(28'h000_0100, 4'b0011, 1'b1, 32'h1234_5678, 32'h5555_AAAA, 3, 0, 0);
        run(28'h0AB_CDEF, 4'hF, 1'b0, 32'h0, 32'h1111_2222, 0, 3, 0);
        run(28'h000_0200, 4'hF, 1'b0, 32'h0, 32'h3333_4444, 1, 2, 0);
        run(28'h000_0300, 4'h1, 1'b0, 32'h0, 32'h7777_8888, 2, 0, 1);
        for (int n = 0; n < 60; n++)
            run(28'($urandom), 4'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
        wbEnable = 1'b0;
        @(negedge clk);
        p_d = 0;
        p_kind = 3;
        wbAddress = 28'h123_4567;
        wbByteSelect = 4'hC;
        wbWriteEnable = 1'b1;
        wbDataWrite = 32'hCAFE_F00D;
        wbEnable = 1'b1;
        b.adr = wbAddress; b.sel = wbByteSelect; b.we = 1'b1; b.wd = wbDataWrite; b.len = TMO;
        bus_q.push_back(b);
        @(negedge clk);
        chk("mid_rst_bus", wb_cyc_o, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_stb", wb_stb_o, 0);
        chk("mid_rst_busy", wbBusy, 1);
        chk("mid_rst_rdata", wbDataRead, ERRD);
        chk("mid_rst_berr", busError, 0);
        force_ack = 1;
        wbEnable = 1'b0;
        repeat (2) @(negedge clk);
        bus_q.delete();
        resp_q.delete();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_cyc", wb_cyc_o, 0);
            chk("post_rst_busy", wbBusy, 1);
        end
        force_ack = 0;
        chk("resp_q_drained", resp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
